// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM state type,
// default geometry and the packed-port slicing helper.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_DEPTH  = 64;
    localparam int unsigned DEF_NREAD  = 2;
    localparam int unsigned DEF_NWRITE = 1;

    // LSB position of port 'port' inside a packed bus of 'w'-bit fields.
    function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned w);
        return port * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
//   in_ctrl_regwrt : per-write-port enable
//   in_rd/in_rdval : packed write addresses / data
//   in_rs          : packed read addresses
//   out_rsval      : packed registered read data
//   in_ctrl_clear  : bulk-clear start pulse
//   out_busy       : clear sweep in progress
// master drives requests (decode/writeback side), slave is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NREAD  = DEF_NREAD,
    parameter int unsigned NWRITE = DEF_NWRITE
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NWRITE-1:0]       in_ctrl_regwrt;
    logic [NWRITE*AW-1:0]    in_rd;
    logic [NWRITE*WIDTH-1:0] in_rdval;
    logic [NREAD*AW-1:0]     in_rs;
    logic [NREAD*WIDTH-1:0]  out_rsval;
    logic                    in_ctrl_clear;
    logic                    out_busy;

    modport master (
        output in_ctrl_regwrt, in_rd, in_rdval, in_rs, in_ctrl_clear,
        input  out_rsval, out_busy
    );

    modport slave (
        input  in_ctrl_regwrt, in_rd, in_rdval, in_rs, in_ctrl_clear,
        output out_rsval, out_busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: after a clear pulse in IDLE, sweeps every entry once
// (one per cycle, ascending) and reports busy for exactly DEPTH cycles.
//   clk, rst      : clock, async active-high reset
//   in_ctrl_clear : start pulse (ignored while sweeping)
//   sweep_we      : array should write zero at sweep_addr this edge
//   sweep_addr    : entry being cleared
//   out_busy      : sweep in progress
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_ctrl_clear,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output logic          out_busy
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_ctrl_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                sweep_we = 1'b1;
                // Counter parks on the last entry rather than wrapping.
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sweep_addr = cnt_q;
    assign out_busy   = (state_q == CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered write-first reads,
// highest-port-wins write priority, optional hard-wired zero register and a
// sequenced bulk clear.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_mp_if slave (write ports, read ports, clear, busy)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned NWRITE   = DEF_NWRITE,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [NREAD*WIDTH-1:0] rsval_q, rsval_d;

    logic                   sweep_we;
    logic [AW-1:0]          sweep_addr;
    logic [AW-1:0]          wa;
    logic [AW-1:0]          ra;

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk           (clk),
        .rst           (rst),
        .in_ctrl_clear (bus.in_ctrl_clear),
        .sweep_we      (sweep_we),
        .sweep_addr    (sweep_addr),
        .out_busy      (bus.out_busy)
    );

    // Next array contents are built first and reads index into them, so the
    // bypass (write-first, port priority, sweep zeroing) falls out for free.
    always_comb begin
        mem_d   = mem_q;
        rsval_d = '0;
        wa      = '0;
        ra      = '0;
        if (sweep_we) begin
            mem_d[sweep_addr] = '0;
        end else begin
            // Ascending port order: the highest-index port writes last and wins.
            for (int unsigned k = 0; k < NWRITE; k++) begin
                wa = bus.in_rd[slice_lsb(k, AW) +: AW];
                if (bus.in_ctrl_regwrt[k] && !(ZERO_REG && (wa == '0))) begin
                    mem_d[wa] = bus.in_rdval[slice_lsb(k, WIDTH) +: WIDTH];
                end
            end
        end
        for (int unsigned j = 0; j < NREAD; j++) begin
            ra = bus.in_rs[slice_lsb(j, AW) +: AW];
            if (ZERO_REG && (ra == '0)) begin
                rsval_d[slice_lsb(j, WIDTH) +: WIDTH] = '0;
            end else begin
                rsval_d[slice_lsb(j, WIDTH) +: WIDTH] = mem_d[ra];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rsval_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rsval_q <= rsval_d;
        end
    end

    assign bus.out_rsval = rsval_q;

endmodule
